seg_scan_decoder: RTL and testbench

- Monitor/receiver for the multiplexed 7-segment display bus. It is the other end of the display path (binary -> BCD -> segment patterns -> scan controller).
- Snoops SEG_COM/SEG_DATA as driven to the board and reconstructs the two-digit value being shown.
- Debounces the value across complete scan frames and reports it as BCD and binary with a one-cycle VALID pulse.
- Used as a self-check on the board and as a scoreboard in display-path benches.

---
 rtl/seg_scan_decoder.sv | 150 +++++++++++++++
 tb/tb_seg_scan_decoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Receiver for the multiplexed two-digit 7-segment scan bus.
// Rebuilds the shown value and accepts it after repeated stable frames.
module seg_scan_decoder #(
  parameter int STABLE_SCANS   = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       CLK,
  input  logic       N_Reset,
  input  logic [7:0] SEG_COM,
  input  logic [7:0] SEG_DATA,
  output logic [7:0] BCD,
  output logic [6:0] BIN,
  output logic       VALID,
  output logic       LOCKED,
  output logic       ERR
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    STB     = 4'(STABLE_SCANS);

  logic [7:0]    com_q;
  logic [6:0]    pat_q;
  logic          was_fe;
  logic          got0;
  logic          got1;
  logic [6:0]    ones_pat;
  logic [6:0]    tens_pat;
  logic [3:0]    cnt;
  logic [7:0]    prev_val;
  logic          accepted;
  logic [TW-1:0] to_cnt;

  logic          unused_dp;
  assign unused_dp = SEG_DATA[0];

  // {ok, digit}
  function automatic logic [4:0] seg_dec(input logic [6:0] p);
    case (p)
      7'b1111110: seg_dec = 5'h10;
      7'b0110000: seg_dec = 5'h11;
      7'b1101101: seg_dec = 5'h12;
      7'b1111001: seg_dec = 5'h13;
      7'b0110011: seg_dec = 5'h14;
      7'b1011011: seg_dec = 5'h15;
      7'b1011111: seg_dec = 5'h16;
      7'b1110000: seg_dec = 5'h17;
      7'b1111111: seg_dec = 5'h18;
      7'b1111011: seg_dec = 5'h19;
      default:    seg_dec = 5'h00;
    endcase
  endfunction

  logic       is_fe;
  logic       is_fd;
  logic       fe_entry;
  logic       frame_end;
  logic [4:0] ones_d;
  logic [4:0] tens_d;
  logic       frame_ok;
  logic [7:0] frame_val;
  logic       same;
  logic [3:0] next_cnt;
  logic [6:0] bin_val;

  assign is_fe     = (com_q == 8'hFE);
  assign is_fd     = (com_q == 8'hFD);
  assign fe_entry  = is_fe && !was_fe;
  assign frame_end = fe_entry && got0 && got1;

  // a blank tens digit is a suppressed leading zero
  assign ones_d = seg_dec(ones_pat);
  assign tens_d = (tens_pat == 7'd0) ? 5'h10
                                     : seg_dec(tens_pat);

  assign frame_ok  = ones_d[4] && tens_d[4];
  assign frame_val = {tens_d[3:0], ones_d[3:0]};
  assign same      = (cnt != 4'd0) && (frame_val == prev_val);
  assign next_cnt  = !same ? 4'd1
                   : (cnt == 4'd15) ? 4'd15
                   : cnt + 4'd1;

  assign bin_val = {tens_d[3:0], 3'b000}
                 + {2'b00, tens_d[3:0], 1'b0}
                 + {3'b000, ones_d[3:0]};

  always_ff @(posedge CLK) begin
    if (!N_Reset) begin
      com_q    <= 8'hFF;
      pat_q    <= 7'd0;
      was_fe   <= 1'b0;
      got0     <= 1'b0;
      got1     <= 1'b0;
      ones_pat <= 7'd0;
      tens_pat <= 7'd0;
      cnt      <= 4'd0;
      prev_val <= 8'd0;
      accepted <= 1'b0;
      to_cnt   <= '0;
      BCD      <= 8'd0;
      BIN      <= 7'd0;
      VALID    <= 1'b0;
      LOCKED   <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      com_q  <= SEG_COM;
      pat_q  <= SEG_DATA[7:1];
      was_fe <= is_fe;
      VALID  <= 1'b0;

      unique case (1'b1)
        is_fe:   ones_pat <= pat_q;
        is_fd:   tens_pat <= pat_q;
        default: ;
      endcase

      // entering the ones slot restarts the frame with ones captured
      got0 <= got0 || is_fe;
      got1 <= fe_entry ? 1'b0 : (got1 || is_fd);

      if (frame_end) begin
        to_cnt <= '0;
        if (!frame_ok) begin
          ERR    <= 1'b1;
          cnt    <= 4'd0;
          LOCKED <= 1'b0;
        end else begin
          ERR      <= 1'b0;
          cnt      <= next_cnt;
          prev_val <= frame_val;
          LOCKED   <= (next_cnt >= STB);
          if ((next_cnt == STB) &&
              ((frame_val != BCD) || !accepted)) begin
            BCD      <= frame_val;
            BIN      <= bin_val;
            VALID    <= 1'b1;
            accepted <= 1'b1;
          end
        end
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + 1'b1;
        if (to_cnt == TO_LAST) begin
          LOCKED <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scan scenarios plus random frames
// checked against a frame-level model of the display value rules.
module tb_seg_scan_decoder;

  localparam int STABLE = 2;
  localparam int TMO    = 50;
  localparam int DWELL  = 4;

  logic       CLK = 1'b0;
  logic       N_Reset;
  logic [7:0] SEG_COM;
  logic [7:0] SEG_DATA;
  logic [7:0] BCD;
  logic [6:0] BIN;
  logic       VALID;
  logic       LOCKED;
  logic       ERR;

  seg_scan_decoder #(
    .STABLE_SCANS(STABLE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK),
    .N_Reset(N_Reset),
    .SEG_COM(SEG_COM),
    .SEG_DATA(SEG_DATA),
    .BCD(BCD),
    .BIN(BIN),
    .VALID(VALID),
    .LOCKED(LOCKED),
    .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int vpulses = 0;
  always @(negedge CLK) if (VALID === 1'b1) vpulses++;

  logic [7:0] seg_tab [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                               8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  int         m_cnt = 0;
  logic [7:0] m_prev = 8'd0;
  logic [7:0] m_bcd = 8'd0;
  logic [6:0] m_bin = 7'd0;
  bit         m_acc = 0;
  bit         m_err = 0;
  bit         m_locked = 0;
  bit         pend = 0;
  logic [7:0] pend_t;
  logic [7:0] pend_o;
  int         exp_pulses = 0;
  int         eval_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit dec(input logic [7:0] p, input bit tens,
                             output int d);
    logic [7:0] e;
    d = 0;
    if (tens && p[7:1] == 7'd0) return 1'b1;
    for (int i = 0; i < 10; i++) begin
      e = seg_tab[i];
      if (p[7:1] == e[7:1]) begin
        d = i;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_prev = 8'd0; m_bcd = 8'd0; m_bin = 7'd0;
    m_acc = 0; m_err = 0; m_locked = 0; pend = 0;
  endtask

  task automatic model_eval(output bit ev, output bit did);
    int tv, ov;
    bit okt, oko;
    logic [7:0] v;
    ev = 0;
    did = pend;
    if (!pend) return;
    pend = 0;
    oko = dec(pend_o, 1'b0, ov);
    okt = dec(pend_t, 1'b1, tv);
    if (!(oko && okt)) begin
      m_err = 1; m_cnt = 0; m_locked = 0;
      return;
    end
    m_err = 0;
    v = 8'(tv * 16 + ov);
    if (m_cnt > 0 && v == m_prev) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
    else m_cnt = 1;
    m_prev = v;
    m_locked = (m_cnt >= STABLE);
    if (m_cnt == STABLE && (v != m_bcd || !m_acc)) begin
      m_bcd = v;
      m_bin = 7'(tv * 10 + ov);
      m_acc = 1;
      ev = 1;
      exp_pulses++;
    end
  endtask

  task automatic check_outs(input bit ev);
    check("bcd", 32'(BCD), 32'(m_bcd));
    check("bin", 32'(BIN), 32'(m_bin));
    check("valid", 32'(VALID), 32'(ev));
    check("locked", 32'(LOCKED), 32'(m_locked));
    check("err", 32'(ERR), 32'(m_err));
  endtask

  task automatic check_frame();
    bit ev, did;
    model_eval(ev, did);
    if (did) eval_cyc = cyc;
    check_outs(ev);
  endtask

  task automatic run_frame(input logic [7:0] t, input logic [7:0] o,
                           input bit bad_com, input int rst_d);
    logic [7:0] sel;
    for (int d = 0; d < 8; d++) begin
      sel = 8'd1 << d;
      SEG_COM = ~sel;
      SEG_DATA = (d == 0) ? o : (d == 1) ? t : 8'($urandom);
      for (int k = 0; k < DWELL; k++) begin
        if (d == rst_d && k == 0) begin
          N_Reset = 1'b0;
          @(posedge CLK); #1;
          N_Reset = 1'b1;
          model_reset();
          check_outs(1'b0);
        end
        @(posedge CLK); #1;
        if (d == 0 && k == 1) check_frame();
      end
      if (d == 1 && bad_com) begin
        SEG_COM = 8'hFC;
        SEG_DATA = 8'hFE;
        repeat (DWELL) begin @(posedge CLK); #1; end
      end
    end
    pend = (rst_d < 0);
    pend_t = t;
    pend_o = o;
  endtask

  initial begin
    int f, val, hold, tt, oo;
    logic dp;
    logic [7:0] tp, op, b0;
    N_Reset = 1'b0;
    SEG_COM = 8'hFF;
    SEG_DATA = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    check_outs(1'b0);
    N_Reset = 1'b1;

    repeat (12) run_frame(8'h60, 8'hF2, 1'b0, -1);
    check("pulses_13", 32'(vpulses), 32'(exp_pulses));
    check("bcd_13", 32'(BCD), 32'h13);

    run_frame(8'h60, 8'hF3, 1'b0, -1);
    run_frame(8'h60, 8'h02, 1'b0, -1);
    repeat (3) run_frame(8'h60, 8'hF2, 1'b0, -1);
    check("pulses_glitch", 32'(vpulses), 32'(exp_pulses));

    repeat (3) run_frame(8'h60, 8'hF2, 1'b1, -1);
    repeat (3) run_frame(8'h00, 8'hE0, 1'b0, -1);
    check("bcd_07", 32'(BCD), 32'h07);
    check("bin_07", 32'(BIN), 32'd7);

    SEG_COM = 8'hFF;
    SEG_DATA = 8'h00;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK); #1;
      if (LOCKED !== 1'b1) break;
    end
    check("timeout_delay", 32'(cyc - eval_cyc), 32'(TMO));
    check("timeout_locked", 32'(LOCKED), 32'd0);
    check("timeout_bcd", 32'(BCD), 32'h07);
    m_locked = 0;
    repeat (2) run_frame(8'h00, 8'hE0, 1'b0, -1);

    b0 = seg_tab[0];
    run_frame(8'h00, 8'hE0, 1'b0, 3);
    repeat (3) run_frame(8'h00, 8'hE0, 1'b0, -1);
    check("bcd_after_rst", 32'(BCD), 32'h07);
    check("pulses_rst", 32'(vpulses), 32'(exp_pulses));

    f = 0;
    while (f < 40) begin
      val = int'($urandom_range(99));
      hold = int'($urandom_range(3, 1));
      for (int h = 0; h < hold; h++) begin
        tt = val / 10;
        oo = val % 10;
        dp = 1'($urandom_range(1));
        tp = seg_tab[tt] | {7'd0, dp};
        if (tt == 0 && $urandom_range(1) != 0) tp = {7'd0, dp};
        else if (tt == 0) tp = b0;
        op = seg_tab[oo] | {7'd0, dp};
        if ($urandom_range(7) == 0) op = 8'($urandom);
        if ($urandom_range(11) == 0) tp = 8'($urandom);
        run_frame(tp, op, $urandom_range(5) == 0, -1);
        f++;
      end
    end
    run_frame(8'h60, 8'hF2, 1'b0, -1);
    check("pulses_final", 32'(vpulses), 32'(exp_pulses));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
